// File: rtl/scan_shift_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scan_ctrl_pkg -- shared definitions for the scan shift controller.
//
// Contents:
//   scan_state_e : controller FSM states (IDLE, LOAD, CAPTURE, UNLOAD, DONE)
//   cnt_width()  : bit counter width for a given chain length,
//                  $clog2(chain_len)+1, so the counter can hold chain_len
//                  itself and never has to wrap
//   CNT_W        : counter width for the default chain length of 16
//
// Optional feature macro used elsewhere in the slice:
//   SCAN_SHIFT_CTRL_COMPARE_EN -- adds EXP / MISMATCH response compare
// ---------------------------------------------------------------------------
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } scan_state_e;

  localparam int DEF_CHAIN_LEN = 16;

  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_CHAIN_LEN);

endpackage

// File: rtl/scan_shift_ctrl_if.sv
// ---------------------------------------------------------------------------
// scan_shift_ctrl_if -- pattern/response handshake and scan chain signals.
//
// Parameter:
//   CHAIN_LEN  : number of scan flops in the driven chain
// Signals:
//   PAT, PAT_VALID, PAT_READY : scan-in pattern handshake (bit 0 first)
//   SE, SI, SO                : scan enable, chain head data, chain tail data
//   RSP, RSP_VALID, RSP_READY : captured response handshake (bit 0 = first
//                               bit sampled from SO)
//   EXP, MISMATCH             : expected response and compare flag, present
//                               only with SCAN_SHIFT_CTRL_COMPARE_EN defined
// Modports:
//   slave  : the controller
//   master : the pattern source / response consumer / scan chain side
// ---------------------------------------------------------------------------
interface scan_shift_ctrl_if #(
  parameter int CHAIN_LEN = 16
);

  logic [CHAIN_LEN-1:0] PAT;
  logic                 PAT_VALID;
  logic                 PAT_READY;
  logic                 SE;
  logic                 SI;
  logic                 SO;
  logic [CHAIN_LEN-1:0] RSP;
  logic                 RSP_VALID;
  logic                 RSP_READY;

`ifdef SCAN_SHIFT_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] EXP;
  logic                 MISMATCH;

  modport slave (
    input  PAT, PAT_VALID, SO, RSP_READY, EXP,
    output PAT_READY, SE, SI, RSP, RSP_VALID, MISMATCH
  );

  modport master (
    output PAT, PAT_VALID, SO, RSP_READY, EXP,
    input  PAT_READY, SE, SI, RSP, RSP_VALID, MISMATCH
  );
`else
  modport slave (
    input  PAT, PAT_VALID, SO, RSP_READY,
    output PAT_READY, SE, SI, RSP, RSP_VALID
  );

  modport master (
    output PAT, PAT_VALID, SO, RSP_READY,
    input  PAT_READY, SE, SI, RSP, RSP_VALID
  );
`endif

endinterface

// File: rtl/scan_shift_ctrl_cnt.sv
// ---------------------------------------------------------------------------
// scan_shift_cnt -- loadable down-counter with registered terminal count.
//
// Parameter:
//   W        : counter width
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (count 0, tc 1)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero, never wraps
//   tc       : registered flag, 1 while the count is zero
// ---------------------------------------------------------------------------
module scan_shift_cnt
  import scan_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;
  logic         tc_r;

  // Next count: load wins, otherwise decrement while non-zero
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_nxt_s = cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register; tc is precomputed from the next count so it is a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
      tc_r  <= 1'b1;
    end else begin
      cnt_r <= cnt_nxt_s;
      tc_r  <= (cnt_nxt_s == {W{1'b0}});
    end
  end

  assign tc = tc_r;

endmodule

// File: rtl/scan_shift_ctrl.sv
// ---------------------------------------------------------------------------
// scan_shift_ctrl -- scan chain shift controller.
//
// Accepts a CHAIN_LEN-bit pattern, shifts it into the chain (LOAD, SE=1),
// spends one capture cycle (SE=0), shifts the response out (UNLOAD, SE=1,
// SI=0) while sampling SO, then presents the response until it is taken.
// Accept-to-RSP_VALID latency is 2*CHAIN_LEN+2 cycles.
//
// Parameter:
//   CHAIN_LEN : scan flops in the chain, 2..256
// Ports:
//   CLK       : clock, rising edge
//   RN        : asynchronous active-low reset
//   bus       : scan_shift_ctrl_if.slave (PAT/RSP handshakes, SE/SI/SO)
//
// Optional feature: SCAN_SHIFT_CTRL_COMPARE_EN adds bus.EXP (registered with
// PAT) and bus.MISMATCH = |(RSP ^ EXP), valid with RSP_VALID, 0 otherwise.
// ---------------------------------------------------------------------------
module scan_shift_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RN,
  scan_shift_ctrl_if.slave     bus
);

  localparam int             CW       = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  scan_state_e          state_r;
  scan_state_e          state_nxt_s;
  logic                 se_r;
  logic                 se_nxt_s;
  logic                 si_r;
  logic                 si_nxt_s;
  logic                 pat_ready_r;
  logic                 pat_ready_nxt_s;
  logic                 rsp_valid_r;
  logic                 rsp_valid_nxt_s;
  logic [CHAIN_LEN-1:0] pat_r;
  logic [CHAIN_LEN-1:0] rsp_r;
  logic [CHAIN_LEN-1:0] rsp_nxt_s;
  logic                 accept_s;
  logic                 pat_shift_s;
  logic                 rsp_shift_s;
  logic                 cnt_load_s;
  logic [CW-1:0]        cnt_val_s;
  logic                 cnt_dec_s;
  logic                 cnt_tc_s;

  // Bit counter: reloaded on every state entry (CHAIN_LEN-1 for the shift
  // states, zero elsewhere) and counted down only inside LOAD/UNLOAD
  scan_shift_cnt #(
    .W (CW)
  ) u_cnt (
    .clk      (CLK),
    .rst_n    (RN),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .tc       (cnt_tc_s)
  );

  // FSM next state plus next values of the registered chain/handshake outputs
  always_comb begin
    state_nxt_s     = state_r;
    se_nxt_s        = 1'b0;
    si_nxt_s        = 1'b0;
    pat_ready_nxt_s = 1'b0;
    rsp_valid_nxt_s = 1'b0;
    accept_s        = 1'b0;
    pat_shift_s     = 1'b0;
    rsp_shift_s     = 1'b0;
    cnt_load_s      = 1'b1;
    cnt_val_s       = CNT_ZERO;
    cnt_dec_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.PAT_VALID && pat_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = LOAD;
          se_nxt_s    = 1'b1;
          si_nxt_s    = bus.PAT[0];
          cnt_val_s   = CNT_LAST;
        end else begin
          pat_ready_nxt_s = 1'b1;
        end
      end
      LOAD: begin
        if (cnt_tc_s) begin
          state_nxt_s = CAPTURE;
        end else begin
          cnt_load_s  = 1'b0;
          cnt_dec_s   = 1'b1;
          se_nxt_s    = 1'b1;
          si_nxt_s    = pat_r[0];
          pat_shift_s = 1'b1;
        end
      end
      CAPTURE: begin
        state_nxt_s = UNLOAD;
        se_nxt_s    = 1'b1;
        cnt_val_s   = CNT_LAST;
      end
      UNLOAD: begin
        rsp_shift_s = 1'b1;
        if (cnt_tc_s) begin
          state_nxt_s     = DONE;
          rsp_valid_nxt_s = 1'b1;
        end else begin
          cnt_load_s = 1'b0;
          cnt_dec_s  = 1'b1;
          se_nxt_s   = 1'b1;
        end
      end
      DONE: begin
        if (bus.RSP_READY) begin
          state_nxt_s     = IDLE;
          pat_ready_nxt_s = 1'b1;
        end else begin
          rsp_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        pat_ready_nxt_s = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs (SE/SI straight from flops)
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_r     <= IDLE;
      se_r        <= 1'b0;
      si_r        <= 1'b0;
      pat_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      se_r        <= se_nxt_s;
      si_r        <= si_nxt_s;
      pat_ready_r <= pat_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
    end
  end

  // Response shift: SO enters at the top so the first sample ends in bit 0
  always_comb begin
    if (rsp_shift_s) begin
      rsp_nxt_s = {bus.SO, rsp_r[CHAIN_LEN-1:1]};
    end else begin
      rsp_nxt_s = rsp_r;
    end
  end

  // Pattern register holds the bits not yet on SI; bit 0 goes straight to
  // the SI flop at accept, so only PAT[CHAIN_LEN-1:1] is kept
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      pat_r <= {CHAIN_LEN{1'b0}};
      rsp_r <= {CHAIN_LEN{1'b0}};
    end else begin
      if (accept_s) begin
        pat_r <= {1'b0, bus.PAT[CHAIN_LEN-1:1]};
      end else if (pat_shift_s) begin
        pat_r <= {1'b0, pat_r[CHAIN_LEN-1:1]};
      end else begin
        pat_r <= pat_r;
      end
      rsp_r <= rsp_nxt_s;
    end
  end

  assign bus.PAT_READY = pat_ready_r;
  assign bus.SE        = se_r;
  assign bus.SI        = si_r;
  assign bus.RSP       = rsp_r;
  assign bus.RSP_VALID = rsp_valid_r;

`ifdef SCAN_SHIFT_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_r;
  logic                 mismatch_r;

  // Expected response captured with the pattern; the flag follows the next
  // response value so it is valid in the same cycle RSP_VALID rises
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      exp_r      <= {CHAIN_LEN{1'b0}};
      mismatch_r <= 1'b0;
    end else begin
      if (accept_s) begin
        exp_r <= bus.EXP;
      end else begin
        exp_r <= exp_r;
      end
      if (rsp_valid_nxt_s) begin
        mismatch_r <= |(rsp_nxt_s ^ exp_r);
      end else begin
        mismatch_r <= 1'b0;
      end
    end
  end

  assign bus.MISMATCH = mismatch_r;
`endif

endmodule
